// File: rtl/run_event_logger_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : run_event_logger_if
// Purpose  : Read-side handshake bundle of the run event logger. The logger
//            (master) presents the FIFO head and occupancy; the consumer
//            (slave) answers with rd_ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface run_event_logger_if #(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 2
);
  logic              rd_valid;
  logic              rd_ready;
  logic [LEN_W-1:0]  rd_len;
  logic [ADDR_W:0]   level;

  modport master (
    output rd_valid,
    output rd_len,
    output level,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_len,
    input  level,
    output rd_ready
  );
endinterface
`default_nettype wire

// File: rtl/run_event_logger.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : run_event_logger
// Purpose  : Measures each interval where the run detector output z_in is
//            high, counts run starts and queues every completed run length
//            in a small FIFO drained through a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module run_event_logger #(
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 2
) (
  input  wire                  clock,
  input  wire                  rst,
  input  wire                  z_in,
  input  wire                  clr,
  run_event_logger_if.master   rd_if,
  output logic [CNT_W-1:0]     evt_count,
  output logic                 busy,
  output logic                 overflow
);

  localparam int              c_DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_FULL    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] c_LEN_MAX = {LEN_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  logic [LEN_W-1:0]    r_run_len;
  logic [CNT_W-1:0]    r_evt_count;
  logic                r_overflow;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_level;
  logic [LEN_W-1:0]    r_mem [c_DEPTH];

  logic w_valid;
  logic w_full;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Handshake and push/pop qualification for this edge
  always_comb begin
    w_valid    = (r_level != '0);
    w_full     = (r_level == c_FULL);
    w_push_req = (r_state == S_RUN) && !z_in;
    w_pop      = w_valid && rd_if.rd_ready;
    // A full FIFO still accepts the new entry when the head leaves on the same edge
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
  end

  // Run tracking FSM: measures run length and counts run starts
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_run_len   <= '0;
      r_evt_count <= '0;
    end else if (clr) begin
      r_state     <= S_IDLE;
      r_run_len   <= '0;
      r_evt_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (z_in) begin
            r_state   <= S_RUN;
            r_run_len <= {{(LEN_W-1){1'b0}}, 1'b1};
            if (r_evt_count != c_CNT_MAX) begin
              r_evt_count <= r_evt_count + CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          if (z_in) begin
            if (r_run_len != c_LEN_MAX) begin
              r_run_len <= r_run_len + LEN_W'(1);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky drop flag
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until qualified by occupancy
  always_ff @(posedge clock) begin
    if (!clr && w_push) begin
      r_mem[r_wr_ptr] <= r_run_len;
    end
  end

  // Output drive; head entry is gated so an empty FIFO presents zero
  always_comb begin
    rd_if.rd_valid = w_valid;
    rd_if.rd_len   = w_valid ? r_mem[r_rd_ptr] : '0;
    rd_if.level    = r_level;
    evt_count      = r_evt_count;
    busy           = (r_state == S_RUN);
    overflow       = r_overflow;
  end

endmodule
`default_nettype wire
